// File: rtl/seg_pkg.sv
// Shared constants, types and the segment lookup for the seven-segment display path.
package seg_pkg;

   localparam int unsigned NUM_DIGITS = 8;
   localparam int unsigned BCD_DIGITS = 10;
   localparam int unsigned NIB_W      = 4;
   localparam int unsigned DATA_W     = NUM_DIGITS * NIB_W;
   localparam int unsigned BCD_W      = BCD_DIGITS * NIB_W;
   localparam int unsigned RADIX_W    = 5;
   localparam int unsigned CNT_W      = $clog2(DATA_W);
   localparam int unsigned SEG_W      = 7;

   localparam logic [RADIX_W-1:0] RADIX_DEC     = 5'd10;
   localparam logic [RADIX_W-1:0] RADIX_HEX     = 5'd16;
   localparam logic [NIB_W-1:0]   SEG_MINUS_NIB = 4'hF;

   // Active-high segment patterns, bit order {g,f,e,d,c,b,a}
   localparam logic [SEG_W-1:0] SEG_BLANK = 7'b000_0000;
   localparam logic [SEG_W-1:0] SEG_DASH  = 7'b100_0000;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CONV,
      ST_FORMAT
   } fmt_state_e;

   typedef struct packed {
      logic [DATA_W-1:0]  din;
      logic [RADIX_W-1:0] radix;
      logic               in_signed;
   } fmt_req_t;

   // Nibble-to-segment map used by the decoder; 4'hF is a dash in decimal mode.
   function automatic logic [SEG_W-1:0] nib_to_seg(input logic [NIB_W-1:0] nib,
                                                   input logic [RADIX_W-1:0] radix);
      logic [SEG_W-1:0] seg;
      seg = SEG_BLANK;
      case (nib)
         4'h0: seg = 7'b011_1111;
         4'h1: seg = 7'b000_0110;
         4'h2: seg = 7'b101_1011;
         4'h3: seg = 7'b100_1111;
         4'h4: seg = 7'b110_0110;
         4'h5: seg = 7'b110_1101;
         4'h6: seg = 7'b111_1101;
         4'h7: seg = 7'b000_0111;
         4'h8: seg = 7'b111_1111;
         4'h9: seg = 7'b110_1111;
         4'hA: seg = 7'b111_0111;
         4'hB: seg = 7'b111_1100;
         4'hC: seg = 7'b011_1001;
         4'hD: seg = 7'b101_1110;
         4'hE: seg = 7'b111_1001;
         default: seg = (radix == RADIX_DEC) ? SEG_DASH : 7'b111_0001;
      endcase
      if (radix != RADIX_DEC && radix != RADIX_HEX) seg = SEG_BLANK;
      return seg;
   endfunction

endpackage

// File: rtl/seg_data_formatter_if.sv
// Request/result bundle between the display register and the segment decoder.
interface seg_data_formatter_if;
   import seg_pkg::*;

   logic               start;
   logic [DATA_W-1:0]  din;
   logic [RADIX_W-1:0] radix;
   logic               in_signed;
   logic               busy;
   logic               done;
   logic [DATA_W-1:0]  seg_data;
   logic [RADIX_W-1:0] radix_out;
   logic               ovf;

   modport master (
      output start, din, radix, in_signed,
      input  busy, done, seg_data, radix_out, ovf
   );

   modport slave (
      input  start, din, radix, in_signed,
      output busy, done, seg_data, radix_out, ovf
   );
endinterface

// File: rtl/bcd_add3_stage.sv
// One double-dabble correction step: every BCD digit of 5 or more gets +3 before the shift.
module bcd_add3_stage
   import seg_pkg::*;
(
   input  logic [BCD_W-1:0] bcd,
   output logic [BCD_W-1:0] bcd_adj_c
);

   always_comb begin
      bcd_adj_c = bcd;
      for (int unsigned i = 0; i < BCD_DIGITS; i++) begin
         if (bcd[i*NIB_W +: NIB_W] >= NIB_W'(5))
            bcd_adj_c[i*NIB_W +: NIB_W] = bcd[i*NIB_W +: NIB_W] + NIB_W'(3);
      end
   end

endmodule

// File: rtl/seg_data_formatter.sv
// Formats a 32-bit value as eight hex nibbles or as signed/unsigned decimal BCD
// for the seven-segment decoder.
module seg_data_formatter
   import seg_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   seg_data_formatter_if.slave  bus
);

   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_W - 1);
   localparam int unsigned      NEG_LO    = (NUM_DIGITS - 1) * NIB_W;

   fmt_state_e         state;
   fmt_req_t           req_q;
   logic [DATA_W-1:0]  shreg;
   logic [BCD_W-1:0]   bcd;
   logic [BCD_W-1:0]   bcd_adj_c;
   logic [CNT_W-1:0]   cnt;
   logic               busy_q;
   logic               done_q;
   logic               ovf_q;
   logic [DATA_W-1:0]  seg_q;
   logic [RADIX_W-1:0] radix_q;

   logic [DATA_W-1:0]  mag_c;
   logic               neg_c;
   logic               dec_ovf_c;
   logic [DATA_W-1:0]  dec_word_c;

   bcd_add3_stage u_add3 (
      .bcd       (bcd),
      .bcd_adj_c (bcd_adj_c)
   );

   // Magnitude of the incoming value; 0x80000000 negated stays 2147483648 unsigned.
   always_comb begin
      mag_c = bus.din;
      if (bus.in_signed && bus.din[DATA_W-1])
         mag_c = ~bus.din + DATA_W'(1);
   end

   // Decimal result word: minus sign takes digit 7, overflow shows all dashes.
   always_comb begin
      neg_c      = req_q.in_signed & req_q.din[DATA_W-1];
      dec_ovf_c  = |bcd[BCD_W-1:DATA_W];
      dec_word_c = bcd[DATA_W-1:0];
      if (neg_c) begin
         dec_ovf_c  = |bcd[BCD_W-1:NEG_LO];
         dec_word_c = {SEG_MINUS_NIB, bcd[NEG_LO-1:0]};
      end
      if (dec_ovf_c)
         dec_word_c = '1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         req_q   <= '0;
         shreg   <= '0;
         bcd     <= '0;
         cnt     <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         ovf_q   <= 1'b0;
         seg_q   <= '0;
         radix_q <= RADIX_HEX;
      end else begin
         done_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               // The done cycle already sits in IDLE; a start there is dropped.
               if (bus.start && !done_q) begin
                  req_q  <= '{din: bus.din, radix: bus.radix, in_signed: bus.in_signed};
                  busy_q <= 1'b1;
                  if (bus.radix == RADIX_DEC) begin
                     shreg <= mag_c;
                     bcd   <= '0;
                     cnt   <= '0;
                     state <= ST_CONV;
                  end else begin
                     state <= ST_FORMAT;
                  end
               end
            end
            ST_CONV: begin
               {bcd, shreg} <= {bcd_adj_c, shreg} << 1;
               cnt          <= cnt + CNT_W'(1);
               if (cnt == LAST_ITER)
                  state <= ST_FORMAT;
            end
            ST_FORMAT: begin
               busy_q <= 1'b0;
               done_q <= 1'b1;
               state  <= ST_IDLE;
               if (req_q.radix == RADIX_DEC) begin
                  seg_q   <= dec_word_c;
                  radix_q <= RADIX_DEC;
                  ovf_q   <= dec_ovf_c;
               end else begin
                  seg_q   <= req_q.din;
                  radix_q <= RADIX_HEX;
                  ovf_q   <= 1'b0;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.seg_data  = seg_q;
   assign bus.radix_out = radix_q;
   assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_seg_data_formatter.sv
// Directed scoreboard bench for seg_data_formatter.
module tb_seg_data_formatter;

   typedef struct {
      string       tag;
      logic [31:0] seg;
      logic [4:0]  radix;
      logic        ovf;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   tests = 0;
   int   fails = 0;
   exp_t sb[$];

   seg_data_formatter_if bus ();

   seg_data_formatter dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Scoreboard: every done pops one expected result.
   always @(negedge clk) begin
      if (bus.done === 1'b1) begin
         if (sb.size() == 0) begin
            chk("spurious_done", 32'(bus.done), 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk({e.tag, "_seg"},   bus.seg_data,        e.seg);
            chk({e.tag, "_radix"}, 32'(bus.radix_out),  32'(e.radix));
            chk({e.tag, "_ovf"},   32'(bus.ovf),        32'(e.ovf));
         end
      end
   end

   task automatic pulse_start(input logic [31:0] d, input logic [4:0] r, input logic s);
      @(negedge clk);
      bus.start     = 1'b1;
      bus.din       = d;
      bus.radix     = r;
      bus.in_signed = s;
      @(negedge clk);
      bus.start     = 1'b0;
   endtask

   task automatic wait_done(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (bus.done !== 1'b1 && n < 100);
      if (bus.done !== 1'b1) n = -1;
   endtask

   task automatic run_conv(input string tag, input logic [31:0] d, input logic [4:0] r,
                           input logic s, input logic [31:0] exp_seg, input logic exp_ovf);
      exp_t e;
      int   n;
      int   lat;
      e.tag   = tag;
      e.seg   = exp_seg;
      e.radix = (r == 5'd10) ? 5'd10 : 5'd16;
      e.ovf   = exp_ovf;
      lat     = (r == 5'd10) ? 33 : 1;
      sb.push_back(e);
      pulse_start(d, r, s);
      chk({tag, "_busy_acc"}, 32'(bus.busy), 32'd1);
      wait_done(n);
      chk({tag, "_latency"}, 32'(n), 32'(lat));
      chk({tag, "_busy_done"}, 32'(bus.busy), 32'd0);
      @(negedge clk);
      chk({tag, "_done_clr"}, 32'(bus.done), 32'd0);
      chk({tag, "_hold"}, bus.seg_data, exp_seg);
   endtask

   initial begin
      #1000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst           = 1'b1;
      bus.start     = 1'b0;
      bus.din       = '0;
      bus.radix     = 5'd16;
      bus.in_signed = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("rst_busy",  32'(bus.busy),      32'd0);
      chk("rst_done",  32'(bus.done),      32'd0);
      chk("rst_ovf",   32'(bus.ovf),       32'd0);
      chk("rst_seg",   bus.seg_data,       32'h0);
      chk("rst_radix", 32'(bus.radix_out), 32'd16);

      run_conv("hex_deadbeef", 32'hDEAD_BEEF, 5'd16, 1'b0, 32'hDEAD_BEEF, 1'b0);
      run_conv("dec_12345678", 32'd12345678, 5'd10, 1'b0, 32'h1234_5678, 1'b0);
      run_conv("dec_zero",     32'd0,        5'd10, 1'b0, 32'h0000_0000, 1'b0);
      run_conv("neg_5",        32'hFFFF_FFFB, 5'd10, 1'b1, 32'hF000_0005, 1'b0);
      run_conv("neg_9999999",  32'(-9999999), 5'd10, 1'b1, 32'hF999_9999, 1'b0);
      run_conv("dec_max8",     32'd99999999, 5'd10, 1'b0, 32'h9999_9999, 1'b0);
      run_conv("dec_ovf9",     32'd100000000, 5'd10, 1'b0, 32'hFFFF_FFFF, 1'b1);
      run_conv("pos_signed",   32'd12345,    5'd10, 1'b1, 32'h0001_2345, 1'b0);
      run_conv("neg_ovf",      32'(-10000000), 5'd10, 1'b1, 32'hFFFF_FFFF, 1'b1);
      run_conv("neg_min",      32'h8000_0000, 5'd10, 1'b1, 32'hFFFF_FFFF, 1'b1);
      run_conv("uns_8000",     32'h8000_0000, 5'd10, 1'b0, 32'hFFFF_FFFF, 1'b1);
      run_conv("hex_signed",   32'hFFFF_FFFF, 5'd16, 1'b1, 32'hFFFF_FFFF, 1'b0);
      run_conv("hex_radix7",   32'h0000_00A7, 5'd7,  1'b0, 32'h0000_00A7, 1'b0);

      // Handshake: restarts while busy and on the done cycle are dropped; input changes ignored.
      begin
         exp_t e;
         e.tag = "hs_42"; e.seg = 32'h0000_0042; e.radix = 5'd10; e.ovf = 1'b0;
         sb.push_back(e);
         pulse_start(32'd42, 5'd10, 1'b0);
         for (int i = 1; i <= 33; i++) begin
            @(negedge clk);
            if (i == 5) begin
               bus.start = 1'b1;
               bus.din   = 32'd999;
            end
            if (i == 6) begin
               bus.start     = 1'b0;
               bus.din       = 32'h0001_2345;
               bus.radix     = 5'd16;
               bus.in_signed = 1'b1;
            end
         end
         chk("hs_done_at_33", 32'(bus.done), 32'd1);
         bus.start = 1'b1;
         bus.din   = 32'h5555_5555;
         @(negedge clk);
         bus.start = 1'b0;
         chk("hs_no_restart_busy", 32'(bus.busy), 32'd0);
         chk("hs_done_clr", 32'(bus.done), 32'd0);
         repeat (40) @(negedge clk);
         chk("hs_idle_busy", 32'(bus.busy), 32'd0);
         chk("hs_seg_held", bus.seg_data, 32'h0000_0042);
      end

      // Reset at E10 of a decimal conversion: discarded, no done.
      pulse_start(32'd12345678, 5'd10, 1'b0);
      repeat (9) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mid_rst_busy",  32'(bus.busy),      32'd0);
      chk("mid_rst_done",  32'(bus.done),      32'd0);
      chk("mid_rst_seg",   bus.seg_data,       32'h0);
      chk("mid_rst_radix", 32'(bus.radix_out), 32'd16);
      chk("mid_rst_ovf",   32'(bus.ovf),       32'd0);
      repeat (40) @(negedge clk);
      chk("mid_rst_idle_busy", 32'(bus.busy), 32'd0);
      run_conv("post_rst", 32'd87654321, 5'd10, 1'b0, 32'h8765_4321, 1'b0);

      repeat (3) @(negedge clk);
      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
